// File: rtl/ghost_pkg.sv
// Shared types and constants for the Flappy Ghost scene generator.
// Holds the game-state encoding, the RGB pixel struct with its palette,
// the default geometry/physics constants and the LFSR step function.
package ghost_pkg;

    localparam int unsigned COORD_W = 11;   // scan coordinates, pipe x, gap y
    localparam int unsigned Y_W     = 12;   // signed ghost y arithmetic
    localparam int unsigned VEL_W   = 8;    // signed ghost velocity
    localparam int unsigned LFSR_W  = 8;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned HOLD_W  = 8;
    localparam int unsigned COL_W   = 4;

    // Default geometry and physics
    localparam int unsigned DEF_SCREEN_W   = 1440;
    localparam int unsigned DEF_FLOOR_Y    = 900;
    localparam int unsigned DEF_GHOST_X    = 300;
    localparam int unsigned DEF_GHOST_Y0   = 400;
    localparam int unsigned DEF_GHOST_SZ   = 32;
    localparam int unsigned DEF_PIPE_W     = 80;
    localparam int unsigned DEF_PIPE_SPEED = 4;
    localparam int unsigned DEF_GAP_BASE   = 200;
    localparam int unsigned DEF_GAP_H      = 240;
    localparam int unsigned DEF_GAP_Y0     = 300;
    localparam int unsigned DEF_FLAP_V     = 12;
    localparam int unsigned DEF_GRAVITY    = 1;
    localparam int unsigned DEF_MAX_FALL   = 15;
    localparam int unsigned DEF_DEAD_HOLD  = 60;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } game_state_e;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    localparam rgb_t COL_GHOST   = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t COL_PIPE    = '{r: 4'h0, g: 4'hC, b: 4'h0};
    localparam rgb_t COL_BG_LIVE = '{r: 4'h4, g: 4'h8, b: 4'hF};
    localparam rgb_t COL_BG_DEAD = '{r: 4'h8, g: 4'h0, b: 4'h0};

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1, shifting left
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/ghost_scene_draw_flap_sync.sv
// Flap button conditioner: 2-FF synchroniser followed by a rising-edge
// detector producing a registered single-cycle pulse.
//   clk, rst_n : pixel clock, async active-low reset
//   btn        : raw asynchronous button
//   pulse      : one-cycle pulse per synchronised rising edge
module flap_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Synchroniser chain plus edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pulse   <= sync2_q & ~sync3_q;
        end
    end

endmodule

// File: rtl/ghost_scene_draw.sv
// Flappy Ghost pixel-colour generator. Runs the game FSM, ghost physics,
// one scrolling pipe pair, collision and score once per frame, and colours
// the scanned pixel with one cycle of latency.
//   clk, rst_n           : pixel clock, async active-low reset
//   btn_flap             : raw asynchronous flap button
//   curr_x, curr_y       : scan position from the timing stage
//   draw_r/g/b           : registered pixel colour
//   score                : pipes passed, saturating
//   game_state           : 0 IDLE, 1 PLAY, 2 DEAD
module ghost_scene_draw
    import ghost_pkg::*;
#(
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned FLOOR_Y    = DEF_FLOOR_Y,
    parameter int unsigned GHOST_X    = DEF_GHOST_X,
    parameter int unsigned GHOST_Y0   = DEF_GHOST_Y0,
    parameter int unsigned GHOST_SZ   = DEF_GHOST_SZ,
    parameter int unsigned PIPE_W     = DEF_PIPE_W,
    parameter int unsigned PIPE_SPEED = DEF_PIPE_SPEED,
    parameter int unsigned GAP_BASE   = DEF_GAP_BASE,
    parameter int unsigned GAP_H      = DEF_GAP_H,
    parameter int unsigned FLAP_V     = DEF_FLAP_V,
    parameter int unsigned GRAVITY    = DEF_GRAVITY,
    parameter int unsigned MAX_FALL   = DEF_MAX_FALL,
    parameter int unsigned DEAD_HOLD  = DEF_DEAD_HOLD,
    parameter int unsigned COLLIDE_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_flap,
    input  logic [COORD_W-1:0]  curr_x,
    input  logic [COORD_W-1:0]  curr_y,
    output logic [COL_W-1:0]    draw_r,
    output logic [COL_W-1:0]    draw_g,
    output logic [COL_W-1:0]    draw_b,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          game_state
);

    localparam logic [COORD_W-1:0]      SCREEN_W_L   = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0]      PIPE_SPEED_L = COORD_W'(PIPE_SPEED);
    localparam logic [COORD_W-1:0]      GAP_BASE_L   = COORD_W'(GAP_BASE);
    localparam logic [COORD_W-1:0]      GAP_Y_RST    = COORD_W'(DEF_GAP_Y0);
    localparam logic [Y_W-1:0]          GHOST_X_L    = Y_W'(GHOST_X);
    localparam logic [Y_W-1:0]          GHOST_SZ_L   = Y_W'(GHOST_SZ);
    localparam logic [Y_W-1:0]          PIPE_W_L     = Y_W'(PIPE_W);
    localparam logic [Y_W-1:0]          GAP_H_L      = Y_W'(GAP_H);
    localparam logic signed [Y_W-1:0]   Y_START      = Y_W'(GHOST_Y0);
    localparam logic signed [Y_W-1:0]   Y_FLOOR_TOP  = Y_W'(FLOOR_Y - GHOST_SZ);
    localparam logic signed [VEL_W-1:0] VEL_FLAP     = -$signed(VEL_W'(FLAP_V));
    localparam logic signed [VEL_W-1:0] VEL_GRAV     = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] VEL_MAX      = VEL_W'(MAX_FALL);
    localparam logic [HOLD_W-1:0]       HOLD_MAX     = HOLD_W'(DEAD_HOLD);

    game_state_e                state_q, state_d;
    logic signed [Y_W-1:0]      ghost_y_q, ghost_y_d;
    logic signed [VEL_W-1:0]    vel_q, vel_d;
    logic [COORD_W-1:0]         pipe_x_q, pipe_x_d;
    logic [COORD_W-1:0]         gap_y_q, gap_y_d;
    logic [SCORE_W-1:0]         score_q, score_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [LFSR_W-1:0]          lfsr_q;
    logic [COORD_W-1:0]         prev_y_q;
    logic                       tick_q;
    logic                       flap_pending_q;
    logic                       flap_pulse;
    logic                       flap_c;
    rgb_t                       draw_q;

    // PLAY-state candidate values
    logic signed [VEL_W-1:0]    vel_inc_c, vel_play_c;
    logic signed [Y_W-1:0]      y_n_c, y_play_c;
    logic [Y_W-1:0]             y_pos_c;
    logic                       ceil_c, floor_c, coll_c, hit_c;
    logic                       pipe_wrap_c, passed_c, x_overlap_c, gap_hit_c;
    logic [COORD_W-1:0]         pipe_x_n_c, gap_n_c;
    logic [Y_W-1:0]             old_right_c, new_right_c, gap_top_c;
    logic [SCORE_W-1:0]         score_n_c;
    rgb_t                       colour_c;

    flap_sync u_flap_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_flap),
        .pulse (flap_pulse)
    );

    // A pulse arriving on the tick cycle is consumed by that tick
    assign flap_c = flap_pending_q | flap_pulse;

    // Frame tick detection, flap latch and LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_y_q       <= '0;
            tick_q         <= 1'b0;
            flap_pending_q <= 1'b0;
            lfsr_q         <= LFSR_SEED;
        end else begin
            prev_y_q <= curr_y;
            tick_q   <= (curr_y == '0) && (prev_y_q != '0);
            if (tick_q) begin
                flap_pending_q <= 1'b0;
                lfsr_q         <= lfsr_next(lfsr_q);
            end else if (flap_pulse) begin
                flap_pending_q <= 1'b1;
            end
        end
    end

    // Physics, pipe scroll, score and collision for one PLAY tick
    always_comb begin
        vel_inc_c  = vel_q + VEL_GRAV;
        vel_play_c = flap_c ? VEL_FLAP : ((vel_inc_c > VEL_MAX) ? VEL_MAX : vel_inc_c);
        y_n_c      = ghost_y_q + Y_W'(vel_play_c);
        ceil_c     = y_n_c[Y_W-1];
        floor_c    = !ceil_c && (y_n_c > Y_FLOOR_TOP);
        y_play_c   = ceil_c ? '0 : (floor_c ? Y_FLOOR_TOP : y_n_c);
        y_pos_c    = y_play_c;

        pipe_wrap_c = pipe_x_q < PIPE_SPEED_L;
        pipe_x_n_c  = pipe_wrap_c ? SCREEN_W_L : (pipe_x_q - PIPE_SPEED_L);
        gap_n_c     = pipe_wrap_c ? (GAP_BASE_L + COORD_W'(lfsr_q)) : gap_y_q;

        old_right_c = {1'b0, pipe_x_q} + PIPE_W_L;
        new_right_c = {1'b0, pipe_x_n_c} + PIPE_W_L;
        passed_c    = (old_right_c >= GHOST_X_L) && (new_right_c < GHOST_X_L);
        score_n_c   = (passed_c && (score_q != '1)) ? (score_q + 1'b1) : score_q;

        gap_top_c   = {1'b0, gap_n_c};
        x_overlap_c = ({1'b0, pipe_x_n_c} < (GHOST_X_L + GHOST_SZ_L)) && (new_right_c > GHOST_X_L);
        gap_hit_c   = (y_pos_c < gap_top_c) || ((y_pos_c + GHOST_SZ_L) > (gap_top_c + GAP_H_L));
        coll_c      = (COLLIDE_EN != 0) && x_overlap_c && gap_hit_c;
        hit_c       = ceil_c || floor_c || coll_c;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: if (flap_c) state_d = ST_PLAY;
                ST_PLAY: if (hit_c) state_d = ST_DEAD;
                ST_DEAD: if (flap_c && (hold_q == HOLD_MAX)) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: next values of the game datapath
    always_comb begin
        ghost_y_d = ghost_y_q;
        vel_d     = vel_q;
        pipe_x_d  = pipe_x_q;
        gap_y_d   = gap_y_q;
        score_d   = score_q;
        hold_d    = hold_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (flap_c) begin
                        vel_d     = VEL_FLAP;
                        ghost_y_d = ghost_y_q + Y_W'(VEL_FLAP);
                    end
                end
                ST_PLAY: begin
                    vel_d     = vel_play_c;
                    ghost_y_d = y_play_c;
                    pipe_x_d  = pipe_x_n_c;
                    gap_y_d   = gap_n_c;
                    score_d   = score_n_c;
                end
                ST_DEAD: begin
                    if (flap_c && (hold_q == HOLD_MAX)) begin
                        ghost_y_d = Y_START;
                        vel_d     = '0;
                        pipe_x_d  = SCREEN_W_L;
                        gap_y_d   = GAP_Y_RST;
                        score_d   = '0;
                        hold_d    = '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Game datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghost_y_q <= Y_START;
            vel_q     <= '0;
            pipe_x_q  <= SCREEN_W_L;
            gap_y_q   <= GAP_Y_RST;
            score_q   <= '0;
            hold_q    <= '0;
        end else begin
            ghost_y_q <= ghost_y_d;
            vel_q     <= vel_d;
            pipe_x_q  <= pipe_x_d;
            gap_y_q   <= gap_y_d;
            score_q   <= score_d;
            hold_q    <= hold_d;
        end
    end

    // Pixel colour: ghost over pipe over background
    always_comb begin
        logic [Y_W-1:0] cx, cy, gy, px, gp;
        logic in_ghost, in_pipe;
        cx       = {1'b0, curr_x};
        cy       = {1'b0, curr_y};
        gy       = ghost_y_q;
        px       = {1'b0, pipe_x_q};
        gp       = {1'b0, gap_y_q};
        in_ghost = (cx >= GHOST_X_L) && (cx < GHOST_X_L + GHOST_SZ_L) &&
                   (cy >= gy) && (cy < gy + GHOST_SZ_L);
        in_pipe  = (cx >= px) && (cx < px + PIPE_W_L) &&
                   ((cy < gp) || (cy >= gp + GAP_H_L));
        if (in_ghost) begin
            colour_c = COL_GHOST;
        end else if (in_pipe) begin
            colour_c = COL_PIPE;
        end else if (state_q == ST_DEAD) begin
            colour_c = COL_BG_DEAD;
        end else begin
            colour_c = COL_BG_LIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_q <= '0;
        end else begin
            draw_q <= colour_c;
        end
    end

    assign draw_r     = draw_q.r;
    assign draw_g     = draw_q.g;
    assign draw_b     = draw_q.b;
    assign score      = score_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_ghost_scene_draw.sv
// Directed bench for ghost_scene_draw: reset, tick detection, start, floor
// death and restart, pipe scroll/score/respawn and pipe collision.
// dut has pipe collision disabled, dut_c has it enabled.
module tb_ghost_scene_draw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_flap = 1'b0;
    logic        btn_c = 1'b0;
    logic [10:0] curr_x = '0;
    logic [10:0] curr_y = 11'd1;
    logic [3:0]  draw_r, draw_g, draw_b;
    logic [3:0]  c_r, c_g, c_b;
    logic [7:0]  score, c_score;
    logic [1:0]  game_state, c_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int y;
        int rgb;
    } pix_vec_t;

    pix_vec_t idle_vecs[9];
    pix_vec_t pipe_vecs[9];

    always #5 clk = ~clk;

    ghost_scene_draw #(.COLLIDE_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .btn_flap(btn_flap),
        .curr_x(curr_x), .curr_y(curr_y),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .score(score), .game_state(game_state)
    );

    ghost_scene_draw #(.COLLIDE_EN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .btn_flap(btn_c),
        .curr_x(curr_x), .curr_y(curr_y),
        .draw_r(c_r), .draw_g(c_g), .draw_b(c_b),
        .score(c_score), .game_state(c_state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One frame boundary: curr_y drops to 0 for a cycle, state updates a cycle later
    task automatic frame();
        curr_y = 11'd0;
        step(1);
        curr_y = 11'd1;
        step(2);
    endtask

    task automatic press(input logic a, input logic b);
        btn_flap = a;
        btn_c    = b;
        step(4);
        btn_flap = 1'b0;
        btn_c    = 1'b0;
        step(4);
    endtask

    task automatic pix(input string nm, input int x, input int y, input int exp);
        curr_x = 11'(x);
        curr_y = 11'(y);
        step(1);
        chk(nm, int'({draw_r, draw_g, draw_b}), exp);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int m_y, m_v, m_px, m_gap, m_score, old_px;
        logic [7:0] m_lfsr, l;
        logic fa, fc;

        idle_vecs[0] = '{10, 10, 'h48F};
        idle_vecs[1] = '{310, 410, 'hFFF};
        idle_vecs[2] = '{300, 400, 'hFFF};
        idle_vecs[3] = '{331, 431, 'hFFF};
        idle_vecs[4] = '{332, 410, 'h48F};
        idle_vecs[5] = '{310, 432, 'h48F};
        idle_vecs[6] = '{299, 410, 'h48F};
        idle_vecs[7] = '{310, 399, 'h48F};
        idle_vecs[8] = '{1439, 100, 'h48F};

        // pipe at x 216..295, gap 300..539
        pipe_vecs[0] = '{220, 100, 'h0C0};
        pipe_vecs[1] = '{220, 299, 'h0C0};
        pipe_vecs[2] = '{220, 300, 'h48F};
        pipe_vecs[3] = '{220, 539, 'h48F};
        pipe_vecs[4] = '{220, 540, 'h0C0};
        pipe_vecs[5] = '{216, 100, 'h0C0};
        pipe_vecs[6] = '{215, 100, 'h48F};
        pipe_vecs[7] = '{295, 100, 'h0C0};
        pipe_vecs[8] = '{296, 100, 'h48F};

        // ---- reset behaviour ----
        step(3);
        chk("rst_draw", int'({draw_r, draw_g, draw_b}), 0);
        chk("rst_state", int'(game_state), 0);
        #2 rst_n = 1'b1;
        curr_x = 11'd310;
        curr_y = 11'd410;
        step(1);
        chk("ghost_px_pre", int'({draw_r, draw_g, draw_b}), 'hFFF);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_draw", int'({draw_r, draw_g, draw_b}), 0);
        chk("async_rst_draw_c", int'({c_r, c_g, c_b}), 0);
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_state", int'(game_state), 0);
        step(1);
        #2 rst_n = 1'b1;
        curr_x = 11'd10;
        curr_y = 11'd10;
        step(1);
        chk("post_rst_bg", int'({draw_r, draw_g, draw_b}), 'h48F);

        // ---- IDLE pixel table ----
        for (int i = 0; i < 9; i++) begin
            pix($sformatf("idle_px%0d", i), idle_vecs[i].x, idle_vecs[i].y, idle_vecs[i].rgb);
        end

        // ---- exactly one tick per 5->0 transition ----
        curr_y = 11'd5;
        step(2);
        curr_y = 11'd0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (dut.tick_q) cnt++;
        end
        curr_y = 11'd1;
        step(1);
        if (dut.tick_q) cnt++;
        chk("one_tick", cnt, 1);
        chk("idle_no_move", int'(dut.ghost_y_q), 400);

        // ---- start and first physics steps ----
        press(1'b1, 1'b0);
        frame();
        chk("start_state", int'(game_state), 1);
        chk("start_vel", int'(dut.vel_q), -12);
        chk("start_y", int'(dut.ghost_y_q), 388);
        chk("c_stays_idle", int'(c_state), 0);
        frame();
        chk("play1_vel", int'(dut.vel_q), -11);
        chk("play1_y", int'(dut.ghost_y_q), 377);

        // ---- fall to the floor ----
        for (int i = 0; i < 200 && game_state != 2'd2; i++) frame();
        chk("floor_dead", int'(game_state), 2);
        chk("floor_y", int'(dut.ghost_y_q), 868);
        pix("dead_bg", 10, 10, 'h800);
        pix("dead_ghost", 310, 870, 'hFFF);
        pix("dead_above_ghost", 310, 867, 'h800);
        curr_y = 11'd1;

        // ---- restart hold-off ----
        repeat (10) frame();
        press(1'b1, 1'b0);
        frame();
        chk("early_flap_ignored", int'(game_state), 2);
        repeat (48) frame();
        press(1'b1, 1'b0);
        frame();
        chk("flap_at_hold59_ignored", int'(game_state), 2);
        press(1'b1, 1'b0);
        frame();
        chk("restart_state", int'(game_state), 0);
        chk("restart_y", int'(dut.ghost_y_q), 400);
        chk("restart_vel", int'(dut.vel_q), 0);
        chk("restart_pipe", int'(dut.pipe_x_q), 1440);
        chk("restart_score", int'(score), 0);

        // ---- fresh reset: no tick while curr_y sits at 0 ----
        rst_n = 1'b0;
        step(2);
        curr_y = 11'd0;
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (dut.tick_q) cnt++;
        end
        curr_y = 11'd1;
        step(1);
        if (dut.tick_q) cnt++;
        chk("no_tick_after_rst", cnt, 0);

        // ---- pipe scroll, score, respawn and collision ----
        m_lfsr = 8'hA5;
        m_y = 400; m_v = 0; m_px = 1440; m_gap = 300; m_score = 0;
        press(1'b1, 1'b1);
        frame();
        m_v = -12;
        m_y = m_y + m_v;
        m_lfsr = lfsr_step(m_lfsr);
        chk("pipe_start_state", int'(game_state), 1);
        chk("pipe_start_state_c", int'(c_state), 1);

        for (int t = 1; t <= 361; t++) begin
            fa = (t % 25) == 0;
            fc = (fa && t <= 275) || (t >= 260 && t <= 278);
            if (fa || fc) press(fa, fc);
            frame();
            m_v = fa ? -12 : ((m_v + 1 > 15) ? 15 : m_v + 1);
            m_y = m_y + m_v;
            old_px = m_px;
            if (m_px < 4) begin
                m_px = 1440;
                m_gap = 200 + int'(m_lfsr);
            end else begin
                m_px = m_px - 4;
            end
            if (old_px + 80 >= 300 && m_px + 80 < 300 && m_score < 255) m_score++;
            m_lfsr = lfsr_step(m_lfsr);
            chk($sformatf("track_y_t%0d", t), int'(dut.ghost_y_q), m_y);
            chk($sformatf("track_px_t%0d", t), int'(dut.pipe_x_q), m_px);
            chk($sformatf("track_score_t%0d", t), int'(score), m_score);
            if (t == 277) chk("coll_not_yet", int'(c_state), 1);
            if (t == 278) begin
                chk("coll_dead", int'(c_state), 2);
                chk("coll_y", int'(dut_c.ghost_y_q), 97);
                chk("nocoll_alive", int'(game_state), 1);
            end
            if (t == 280) begin
                chk("y_t280", int'(dut.ghost_y_q), 343);
                pix("ghost_over_pipe", 325, 350, 'hFFF);
                pix("pipe_beside_ghost", 325, 10, 'h0C0);
                curr_y = 11'd1;
            end
            if (t == 306) begin
                chk("pipe_t306", int'(dut.pipe_x_q), 216);
                chk("score_t306", int'(score), 1);
                for (int i = 0; i < 9; i++) begin
                    pix($sformatf("pipe_px%0d", i), pipe_vecs[i].x, pipe_vecs[i].y, pipe_vecs[i].rgb);
                end
                curr_y = 11'd1;
            end
            if (t == 360) chk("pipe_t360", int'(dut.pipe_x_q), 0);
            if (t == 361) begin
                l = 8'hA5;
                repeat (361) l = lfsr_step(l);
                chk("pipe_t361", int'(dut.pipe_x_q), 1440);
                chk("gap_t361", int'(dut.gap_y_q), 200 + int'(l));
                chk("gap_model_t361", int'(dut.gap_y_q), m_gap);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
